// File: rtl/fp_mult_seq_pkg.sv
// Shared types and constants for the sequential FP32 multiplier.
package fp_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        UNPACK = 3'd1,
        MULT   = 3'd2,
        NORM   = 3'd3,
        ROUND  = 3'd4,
        DONE   = 3'd5
    } fp_state_t;

    localparam int          BIAS      = 127;
    localparam int          EXP_MAX   = 255;
    localparam int          MANT_W    = 23;
    localparam logic [31:0] QNAN      = 32'h7FC00000;
    localparam logic [31:0] POS_INF   = 32'h7F800000;
    localparam logic [4:0]  LAST_STEP = 5'd23;

endpackage

// File: rtl/fp_mult_seq_mant_shift_add.sv
// 24x24 iterative shift-add mantissa multiplier. One partial product per step,
// selected by the externally sequenced bit index cnt.
module mant_shift_add (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        step,
    input  logic [4:0]  cnt,
    input  logic [23:0] mcand,
    input  logic [23:0] mplier,
    output logic [47:0] prod
);

    logic [23:0] mcand_q, mcand_d;
    logic [23:0] mplier_q, mplier_d;
    logic [47:0] acc_q, acc_d;

    // Next-state: load operands and clear accumulator, or add one shifted partial product.
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        if (load) begin
            mcand_d  = mcand;
            mplier_d = mplier;
            acc_d    = 48'd0;
        end else if (step && mplier_q[cnt]) begin
            acc_d = acc_q + ({24'd0, mcand_q} << cnt);
        end else begin
            acc_d = acc_q;
        end
    end

    // Operand and accumulator registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_q  <= 24'd0;
            mplier_q <= 24'd0;
            acc_q    <= 48'd0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

    assign prod = acc_q;

endmodule

// File: rtl/fp_mult_seq.sv
// Multi-cycle FP32 multiply sequencer: start/busy/done handshake, shift-add
// mantissa core, normalise, round, special-operand handling, held result.
module fp_mult_seq
    import fp_pkg::*;
#(
    parameter bit ROUND_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow,
    output logic        invalid
);

    fp_state_t          state_q, state_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [31:0]        a_q, a_d, b_q, b_d;
    logic               sign_q, sign_d;
    logic signed [9:0]  exp_q, exp_d;
    logic [22:0]        mant_q, mant_d;
    logic               guard_q, guard_d, sticky_q, sticky_d;
    logic [31:0]        result_q, result_d;
    logic               ovf_q, ovf_d, unf_q, unf_d, inv_q, inv_d;
    logic               busy_q, busy_d, done_q, done_d;

    logic [47:0]        prod_s;
    logic               a_emax_s, b_emax_s, a_nan_s, b_nan_s, a_inf_s, b_inf_s;
    logic               a_zero_s, b_zero_s;
    logic               round_inc_s;
    logic [23:0]        mant_sum_s;
    logic signed [9:0]  exp_rnd_s;

    // Operand classification; denormals count as zero.
    assign a_emax_s = (a_q[30:23] == 8'(EXP_MAX));
    assign b_emax_s = (b_q[30:23] == 8'(EXP_MAX));
    assign a_nan_s  = a_emax_s && (a_q[MANT_W-1:0] != 23'd0);
    assign b_nan_s  = b_emax_s && (b_q[MANT_W-1:0] != 23'd0);
    assign a_inf_s  = a_emax_s && (a_q[MANT_W-1:0] == 23'd0);
    assign b_inf_s  = b_emax_s && (b_q[MANT_W-1:0] == 23'd0);
    assign a_zero_s = (a_q[30:23] == 8'd0);
    assign b_zero_s = (b_q[30:23] == 8'd0);

    // Round-to-nearest-even increment; a mantissa carry leaves the fraction at zero.
    assign round_inc_s = ROUND_EN && guard_q && (sticky_q || mant_q[0]);
    assign mant_sum_s  = {1'b0, mant_q} + {23'd0, round_inc_s};
    assign exp_rnd_s   = exp_q + (mant_sum_s[23] ? 10'sd1 : 10'sd0);

    mant_shift_add u_core (
        .clk    (clk),
        .reset  (reset),
        .load   (state_q == UNPACK),
        .step   (state_q == MULT),
        .cnt    (cnt_q),
        .mcand  ({1'b1, a_q[MANT_W-1:0]}),
        .mplier ({1'b1, b_q[MANT_W-1:0]}),
        .prod   (prod_s)
    );

    // FSM next-state and datapath next values.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        mant_d   = mant_q;
        guard_d  = guard_q;
        sticky_d = sticky_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        inv_d    = inv_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d      = op_a;
                    b_d      = op_b;
                    result_d = 32'd0;
                    ovf_d    = 1'b0;
                    unf_d    = 1'b0;
                    inv_d    = 1'b0;
                    state_d  = UNPACK;
                end else begin
                    state_d = IDLE;
                end
            end
            UNPACK: begin
                sign_d = a_q[31] ^ b_q[31];
                exp_d  = $signed({2'b00, a_q[30:23]}) + $signed({2'b00, b_q[30:23]}) - 10'(BIAS);
                cnt_d  = 5'd0;
                if (a_nan_s || b_nan_s || (a_inf_s && b_zero_s) || (b_inf_s && a_zero_s)) begin
                    result_d = QNAN;
                    inv_d    = 1'b1;
                    state_d  = DONE;
                end else if (a_inf_s || b_inf_s) begin
                    result_d = {a_q[31] ^ b_q[31], POS_INF[30:0]};
                    state_d  = DONE;
                end else if (a_zero_s || b_zero_s) begin
                    result_d = {a_q[31] ^ b_q[31], 31'd0};
                    state_d  = DONE;
                end else begin
                    state_d = MULT;
                end
            end
            MULT: begin
                if (cnt_q == LAST_STEP) begin
                    cnt_d   = 5'd0;
                    state_d = NORM;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            NORM: begin
                if (prod_s[47]) begin
                    mant_d   = prod_s[46:24];
                    guard_d  = prod_s[23];
                    sticky_d = |prod_s[22:0];
                    exp_d    = exp_q + 10'sd1;
                end else begin
                    mant_d   = prod_s[45:23];
                    guard_d  = prod_s[22];
                    sticky_d = |prod_s[21:0];
                end
                state_d = ROUND;
            end
            ROUND: begin
                if (exp_rnd_s >= 10'sd255) begin
                    result_d = {sign_q, POS_INF[30:0]};
                    ovf_d    = 1'b1;
                end else if (exp_rnd_s <= 10'sd0) begin
                    result_d = {sign_q, 31'd0};
                    unf_d    = 1'b1;
                end else begin
                    result_d = {sign_q, exp_rnd_s[7:0], mant_sum_s[22:0]};
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 5'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            sign_q   <= 1'b0;
            exp_q    <= 10'sd0;
            mant_q   <= 23'd0;
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
            result_q <= 32'd0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            inv_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            mant_q   <= mant_d;
            guard_q  <= guard_d;
            sticky_q <= sticky_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            inv_q    <= inv_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign invalid   = inv_q;

endmodule

// File: tb/tb_fp_mult_seq.sv
// Self-checking bench: two DUTs (round-to-nearest-even and truncate) share
// stimulus; a behavioural FP32 model predicts timing, result and flags.
module tb_fp_mult_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] op_a, op_b;

    logic        busy1, done1, ovf1, unf1, inv1;
    logic [31:0] res1;
    logic        busy0, done0, ovf0, unf0, inv0;
    logic [31:0] res0;

    fp_mult_seq #(.ROUND_EN(1'b1)) dut_rne (
        .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
        .busy(busy1), .done(done1), .result(res1),
        .overflow(ovf1), .underflow(unf1), .invalid(inv1)
    );

    fp_mult_seq #(.ROUND_EN(1'b0)) dut_trunc (
        .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
        .busy(busy0), .done(done0), .result(res0),
        .overflow(ovf0), .underflow(unf0), .invalid(inv0)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    // Model state: {special, invalid, underflow, overflow, result}
    int          acc_cyc  = -100;
    int          done_cyc = -100;
    logic [35:0] m1 = 36'd0, m0 = 36'd0, mp1 = 36'd0, mp0 = 36'd0;

    // Reference FP32 product from the number-format rules.
    function automatic logic [35:0] fmodel(input logic [31:0] a, input logic [31:0] b, input bit rnd);
        bit s, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, inv, unf, ovf, spc;
        int ea, eb, e, sh;
        longint unsigned ma, mb, p, kept, rem, half;
        logic [31:0] r;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        ma = {40'd0, 1'b1, a[22:0]};
        mb = {40'd0, 1'b1, b[22:0]};
        nan_a  = (ea == 255) && (a[22:0] != 23'd0);
        nan_b  = (eb == 255) && (b[22:0] != 23'd0);
        inf_a  = (ea == 255) && (a[22:0] == 23'd0);
        inf_b  = (eb == 255) && (b[22:0] == 23'd0);
        zero_a = (ea == 0);
        zero_b = (eb == 0);
        inv = 1'b0; unf = 1'b0; ovf = 1'b0; spc = 1'b1;
        if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a)) begin
            r = 32'h7FC00000; inv = 1'b1;
        end else if (inf_a || inf_b) begin
            r = {s, 8'hFF, 23'd0};
        end else if (zero_a || zero_b) begin
            r = {s, 31'd0};
        end else begin
            spc = 1'b0;
            p = ma * mb;
            e = ea + eb - 127;
            if (p >= (64'd1 << 47)) begin sh = 24; e = e + 1; end
            else sh = 23;
            kept = p >> sh;
            rem  = p - (kept << sh);
            half = 64'd1 << (sh - 1);
            if (rnd && (rem > half || (rem == half && kept[0]))) kept = kept + 64'd1;
            if (kept == (64'd1 << 24)) begin kept = kept >> 1; e = e + 1; end
            if (e >= 255) begin r = {s, 8'hFF, 23'd0}; ovf = 1'b1; end
            else if (e <= 0) begin r = {s, 31'd0}; unf = 1'b1; end
            else r = {s, 8'(e), kept[22:0]};
        end
        return {spc, inv, unf, ovf, r};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Pin the model itself against hand-computed values.
    task automatic pin(input string name, input logic [31:0] a, input logic [31:0] b, input bit rnd,
                       input logic [31:0] exp_r, input logic [2:0] exp_f, input bit exp_spc);
        logic [35:0] m;
        m = fmodel(a, b, rnd);
        check({name, " model result"}, m[31:0], exp_r);
        check({name, " model flags"}, {29'd0, m[34:32]}, {29'd0, exp_f});
        check({name, " model special"}, {31'd0, m[35]}, {31'd0, exp_spc});
    endtask

    logic        e_busy, e_done;
    logic [35:0] e_m1, e_m0;

    // Cycle-by-cycle comparison of both DUTs against the model.
    always @(negedge clk) begin
        if (!reset) begin
            e_busy = (cyc >= acc_cyc) && (cyc <= done_cyc);
            e_done = (cyc == done_cyc);
            e_m1   = (cyc >= done_cyc) ? m1 : ((cyc >= acc_cyc) ? 36'd0 : mp1);
            e_m0   = (cyc >= done_cyc) ? m0 : ((cyc >= acc_cyc) ? 36'd0 : mp0);
            check("busy rne",   {31'd0, busy1}, {31'd0, e_busy});
            check("done rne",   {31'd0, done1}, {31'd0, e_done});
            check("result rne", res1, e_m1[31:0]);
            check("flags rne",  {29'd0, inv1, unf1, ovf1}, {29'd0, e_m1[34:32]});
            check("busy trunc",   {31'd0, busy0}, {31'd0, e_busy});
            check("done trunc",   {31'd0, done0}, {31'd0, e_done});
            check("result trunc", res0, e_m0[31:0]);
            check("flags trunc",  {29'd0, inv0, unf0, ovf0}, {29'd0, e_m0[34:32]});
        end
    end

    // Wait (bounded) until the model says both DUTs have been idle for a cycle.
    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (cyc < done_cyc + 3 && n < 100);
    endtask

    // Issue one operation when idle and update the model.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b);
        wait_idle();
        op_a = a; op_b = b; start = 1'b1;
        mp1 = m1; mp0 = m0;
        m1 = fmodel(a, b, 1'b1);
        m0 = fmodel(a, b, 1'b0);
        acc_cyc  = cyc + 1;
        done_cyc = acc_cyc + (m1[35] ? 1 : 27);
        @(posedge clk); #1;
        start = 1'b0;
        op_a = $urandom; op_b = $urandom;
    endtask

    function automatic logic [31:0] rand_fp();
        int sel;
        logic [7:0] e;
        logic [22:0] f;
        sel = $urandom_range(0, 11);
        f = 23'($urandom);
        if (sel == 0) e = 8'd0;
        else if (sel == 1) begin e = 8'hFF; if ($urandom_range(0, 1) == 0) f = 23'd0; end
        else if (sel == 2) e = 8'($urandom_range(1, 254));
        else if (sel == 3) begin e = 8'($urandom_range(1, 254)); f = 23'h7FFFFF; end
        else e = 8'($urandom_range(90, 164));
        return {1'($urandom), e, f};
    endfunction

    initial begin
        reset = 1'b0; start = 1'b0; op_a = 32'd0; op_b = 32'd0;
        #1 reset = 1'b1;
        #1;
        check("reset busy",   {31'd0, busy1}, 32'd0);
        check("reset done",   {31'd0, done1}, 32'd0);
        check("reset result", res1, 32'd0);
        check("reset flags",  {29'd0, inv0, unf0, ovf0}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        pin("2x3",     32'h40000000, 32'h40400000, 1'b1, 32'h40C00000, 3'b000, 1'b0);
        pin("1.5sq",   32'h3FC00000, 32'h3FC00000, 1'b1, 32'h40100000, 3'b000, 1'b0);
        pin("rne",     32'h3FC00001, 32'h3FC00001, 1'b1, 32'h40100002, 3'b000, 1'b0);
        pin("trunc",   32'h3FC00001, 32'h3FC00001, 1'b0, 32'h40100001, 3'b000, 1'b0);
        pin("ovf",     32'h7F7FFFFF, 32'h40000000, 1'b1, 32'h7F800000, 3'b001, 1'b0);
        pin("unf",     32'h00800000, 32'h00800000, 1'b1, 32'h00000000, 3'b010, 1'b0);
        pin("inf*0",   32'h7F800000, 32'h00000000, 1'b1, 32'h7FC00000, 3'b100, 1'b1);
        pin("neg*0",   32'hC0000000, 32'h00000000, 1'b1, 32'h80000000, 3'b000, 1'b1);

        do_op(32'h40000000, 32'h40400000);
        do_op(32'h3FC00000, 32'h3FC00000);
        do_op(32'h3FC00001, 32'h3FC00001);
        do_op(32'h7F7FFFFF, 32'h40000000);
        do_op(32'h00800000, 32'h00800000);
        do_op(32'h7F800000, 32'h00000000);
        do_op(32'hC0000000, 32'h00000000);
        do_op(32'h7FC00123, 32'h3F800000);
        do_op(32'hFF800000, 32'h40000000);

        // start pulse mid-multiply with other operands must be ignored
        do_op(32'h40000000, 32'h40400000);
        repeat (8) @(posedge clk);
        #1 op_a = 32'h3F800000; op_b = 32'hC1200000; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;

        // asynchronous reset ten cycles into an operation
        do_op(32'h3FC00001, 32'h40490FDB);
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("abort busy",   {31'd0, busy1}, 32'd0);
        check("abort result", res1, 32'd0);
        check("abort done",   {31'd0, done0}, 32'd0);
        m1 = 36'd0; m0 = 36'd0; mp1 = 36'd0; mp0 = 36'd0;
        acc_cyc = -100; done_cyc = -100;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (35) @(posedge clk);
        #1;
        do_op(32'h40000000, 32'h40400000);

        for (int i = 0; i < 40; i++) begin
            do_op(rand_fp(), rand_fp());
        end
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Watchdog so the bench always ends.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

endmodule

// File: doc/fp_mult_seq.md
Name: fp_mult_seq

Overview:
- Multi-cycle IEEE-754 single-precision multiply sequencer.
- Replaces the purely combinational multiplier feeding the operand-entry/display control unit.
- Accepts two 32-bit operands on a start/busy/done handshake and runs a 24-step shift-add mantissa multiply.
- Normalises, rounds, handles special operands, and holds the result plus exception flags for the 7-segment display path.

Parameters:
ROUND_EN, 1, 1 = round-to-nearest-even, 0 = truncate toward zero

Ports:
clk       in   1   clock, rising edge
reset     in   1   reset: asynchronous, active-high
start     in   1   request; sampled only in IDLE
op_a      in   32  operand A (FP32), captured when start is accepted
op_b      in   32  operand B (FP32), captured when start is accepted
busy      out  1   high in every state except IDLE
done      out  1   one-cycle pulse; result/flags valid from this cycle on
result    out  32  FP32 product, held until the next accepted start
overflow  out  1   result saturated to ±inf
underflow out  1   result flushed to ±0
invalid   out  1   NaN operand or inf×0; result = qNaN

Behaviour:
- Reset (async, any state, including mid-operation):
  - state = IDLE; busy = 0, done = 0, result = 0, all flags = 0.
  - Counter and accumulator cleared; no done pulse for the aborted operation.
- States: IDLE → UNPACK → MULT → NORM → ROUND → DONE → IDLE.
- IDLE:
  - If start = 1 at edge E: latch op_a/op_b, clear result and flags, go to UNPACK.
  - start in any other state is ignored. No queueing.
- UNPACK (1 cycle):
  - sign = sa ^ sb.
  - exp = ea + eb − 127, held in a 10-bit signed register.
  - Mantissas get the hidden 1 prepended (24 bits).
  - Special cases go directly to DONE:
    - Either operand NaN (exp 255, mant ≠ 0), or inf×0 → 0x7FC00000, invalid = 1.
    - Either operand inf (other operand non-zero) → {sign, 0xFF, 0}.
    - Either operand exp = 0 (zero or denormal; denormals are treated as zero) → {sign, 31'b0}, no flags.
- MULT (exactly 24 cycles):
  - 5-bit counter 0..23.
  - Each cycle: if multiplier bit[cnt] = 1, add (multiplicand << cnt) into a 48-bit accumulator.
  - Counter wraps to 0 on exit.
- NORM (1 cycle):
  - If prod[47] = 1: mant = prod[46:24], guard = prod[23], sticky = |prod[22:0], exp += 1.
  - Else: mant = prod[45:23], guard = prod[22], sticky = |prod[21:0].
- ROUND (1 cycle):
  - ROUND_EN = 1: increment mant if guard & (sticky | mant[0]).
  - Mantissa carry-out sets mant to 0 and adds 1 to exp.
  - exp ≥ 255 → {sign, 0xFF, 0}, overflow = 1.
  - exp ≤ 0 → {sign, 31'b0}, underflow = 1.
- DONE (1 cycle): done = 1, busy = 1; next state IDLE.
- Latency, with start sampled at edge E:
  - Normal operands: done high between edges E+27 and E+28.
  - Special operands: done high between edges E+1 and E+2.
  - Earliest next accept: edge E+28 (normal) or E+2 (special).
- result and flags are registered and stable from done until the next accepted start or reset.

Decomposition:
- Package fp_pkg:
  - state enum fp_state_t {IDLE, UNPACK, MULT, NORM, ROUND, DONE}.
  - Constants: BIAS = 127, EXP_MAX = 255, MANT_W = 23, QNAN = 32'h7FC00000, POS_INF = 32'h7F800000.
- One sub-module: mant_shift_add.
  - 24×24 iterative shift-add core with load/step/cnt interface and a 48-bit product register.
  - Sequenced by the fp_mult_seq FSM.

Test Plan:
- 0x40000000 × 0x40400000 (2×3) → result 0x40C00000, flags 0, done exactly at E+27, busy high E..E+28.
- 0x3FC00000 × 0x3FC00000 (1.5×1.5) → 0x40100000; exercises the prod[47] normalisation and exponent increment.
- 0x3FC00001 × 0x3FC00001 → 0x40100002 with ROUND_EN = 1, 0x40100001 with ROUND_EN = 0 (guard = 1, sticky = 1).
- Overflow and underflow cases:
  - 0x7F7FFFFF × 0x40000000 → 0x7F800000, overflow = 1.
  - 0x00800000 × 0x00800000 → 0x00000000, underflow = 1.
- Special operands (each done at E+1):
  - 0x7F800000 × 0x00000000 → 0x7FC00000, invalid = 1.
  - 0xC0000000 × 0x00000000 → 0x80000000, no flags.
- Control and reset:
  - start pulsed during MULT with different operands → ignored; the original product completes.
  - reset asserted at E+10 → busy = 0, result = 0 immediately; no done pulse.
  - A fresh start after reset gives the correct result.
